// File: rtl/branch_sequencer.sv
// Control-flow sequencer for the 19-bit execute stage: turns resolved branch/call/ret
// events into a one-cycle PC redirect plus a fixed-length flush, backed by a return-address stack.
module branch_sequencer #(
  parameter int unsigned STACK_DEPTH  = 8,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 valid_i,
  input  logic                                 is_b_type_i,
  input  logic                                 is_call_i,
  input  logic                                 is_ret_i,
  input  logic                                 branch_taken_i,
  input  logic                                 stall_i,
  input  logic [18:0]                          pc_i,
  input  logic [18:0]                          target_i,
  output logic                                 ready_o,
  output logic                                 redirect_o,
  output logic [18:0]                          redirect_pc_o,
  output logic                                 flush_o,
  output logic [$clog2(STACK_DEPTH+1)-1:0]     depth_o,
  output logic                                 ovf_o,
  output logic                                 unf_o
);

  localparam int unsigned DW = $clog2(STACK_DEPTH + 1);
  localparam int unsigned AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int unsigned CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [DW-1:0] FULL_LEVEL = DW'(STACK_DEPTH);
  localparam logic [CW-1:0] FLUSH_LOAD = CW'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REDIRECT,
    ST_FLUSH
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] flush_cnt;
  logic [CW-1:0] flush_cnt_next;

  logic [18:0]   stack_mem [STACK_DEPTH];
  logic [DW-1:0] sp;
  logic          stack_full;
  logic          stack_empty;
  logic [18:0]   stack_top;
  logic [18:0]   pc_plus1;

  logic          accept;
  logic          take_ret;
  logic          take_call;
  logic          take_br;
  logic          redirect_req;
  logic          do_push;
  logic          do_pop;
  logic [18:0]   redirect_target;

  assign ready_o     = (state == ST_IDLE) && !stall_i;
  assign accept      = valid_i && ready_o;
  assign pc_plus1    = pc_i + 19'd1;
  assign stack_full  = (sp == FULL_LEVEL);
  assign stack_empty = (sp == '0);
  assign stack_top   = stack_mem[AW'(sp - DW'(1))];

  // Ret outranks call, call outranks a conditional branch when several flags are set.
  assign take_ret  = is_ret_i;
  assign take_call = !is_ret_i && is_call_i;
  assign take_br   = !is_ret_i && !is_call_i && is_b_type_i && branch_taken_i;

  assign redirect_req = accept && (take_ret || take_call || take_br);
  assign do_push      = accept && take_call && !stack_full;
  assign do_pop       = accept && take_ret && !stack_empty;

  always_comb begin
    redirect_target = target_i;
    if (take_ret) begin
      redirect_target = stack_empty ? pc_plus1 : stack_top;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      flush_cnt <= '0;
    end else begin
      state     <= state_next;
      flush_cnt <= flush_cnt_next;
    end
  end

  always_comb begin
    state_next     = state;
    flush_cnt_next = flush_cnt;
    unique case (state)
      ST_IDLE: begin
        if (redirect_req) begin
          state_next = ST_REDIRECT;
        end
      end
      ST_REDIRECT: begin
        state_next     = ST_FLUSH;
        flush_cnt_next = FLUSH_LOAD;
      end
      ST_FLUSH: begin
        if (flush_cnt == '0) begin
          state_next = ST_IDLE;
        end else begin
          flush_cnt_next = flush_cnt - CW'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      redirect_o    <= 1'b0;
      redirect_pc_o <= '0;
      flush_o       <= 1'b0;
    end else begin
      redirect_o <= (state_next == ST_REDIRECT);
      flush_o    <= (state_next != ST_IDLE);
      if (redirect_req) begin
        redirect_pc_o <= redirect_target;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sp    <= '0;
      ovf_o <= 1'b0;
      unf_o <= 1'b0;
    end else begin
      if (do_push) begin
        sp <= sp + DW'(1);
      end else if (do_pop) begin
        sp <= sp - DW'(1);
      end
      if (accept && take_call && stack_full) begin
        ovf_o <= 1'b1;
      end
      if (accept && take_ret && stack_empty) begin
        unf_o <= 1'b1;
      end
    end
  end

  // Entries are never cleared; only the pointer decides what is live.
  always_ff @(posedge clk) begin
    if (do_push) begin
      stack_mem[AW'(sp)] <= pc_plus1;
    end
  end

  assign depth_o = sp;

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed, table-driven bench for branch_sequencer with default parameters
// (STACK_DEPTH=8, FLUSH_CYCLES=2).
module tb_branch_sequencer;

  logic        clk;
  logic        reset_n;
  logic        valid_i;
  logic        is_b_type_i;
  logic        is_call_i;
  logic        is_ret_i;
  logic        branch_taken_i;
  logic        stall_i;
  logic [18:0] pc_i;
  logic [18:0] target_i;
  logic        ready_o;
  logic        redirect_o;
  logic [18:0] redirect_pc_o;
  logic        flush_o;
  logic [3:0]  depth_o;
  logic        ovf_o;
  logic        unf_o;

  int checks;
  int errors;

  typedef struct {
    logic        valid;
    logic        b;
    logic        call;
    logic        ret;
    logic        taken;
    logic        stall;
    logic [18:0] pc;
    logic [18:0] target;
    logic        exp_ready;
    logic        exp_redirect;
    logic [18:0] exp_rpc;
    logic        exp_flush;
    logic [3:0]  exp_depth;
    logic        exp_ovf;
    logic        exp_unf;
  } vec_t;

  vec_t vecs[$];
  int   vec_idx;

  branch_sequencer #(
    .STACK_DEPTH  (8),
    .FLUSH_CYCLES (2)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .valid_i        (valid_i),
    .is_b_type_i    (is_b_type_i),
    .is_call_i      (is_call_i),
    .is_ret_i       (is_ret_i),
    .branch_taken_i (branch_taken_i),
    .stall_i        (stall_i),
    .pc_i           (pc_i),
    .target_i       (target_i),
    .ready_o        (ready_o),
    .redirect_o     (redirect_o),
    .redirect_pc_o  (redirect_pc_o),
    .flush_o        (flush_o),
    .depth_o        (depth_o),
    .ovf_o          (ovf_o),
    .unf_o          (unf_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(input logic valid, input logic b, input logic call,
                              input logic ret, input logic taken, input logic stall,
                              input logic [18:0] pc, input logic [18:0] target,
                              input logic ready, input logic redirect, input logic [18:0] rpc,
                              input logic flush, input logic [3:0] depth,
                              input logic ovf, input logic unf);
    vec_t v;
    v.valid = valid; v.b = b; v.call = call; v.ret = ret; v.taken = taken; v.stall = stall;
    v.pc = pc; v.target = target;
    v.exp_ready = ready; v.exp_redirect = redirect; v.exp_rpc = rpc; v.exp_flush = flush;
    v.exp_depth = depth; v.exp_ovf = ovf; v.exp_unf = unf;
    return v;
  endfunction

  // Three cycles after a redirect: ready low throughout, a competing taken branch is ignored.
  task automatic push_flush(input logic [18:0] rpc, input logic [3:0] depth,
                            input logic ovf, input logic unf, input logic stall);
    vecs.push_back(mk(1, 1, 0, 0, 1, stall, 19'h00555, 19'h00555, 0, 0, rpc, 1, depth, ovf, unf));
    vecs.push_back(mk(1, 1, 0, 0, 1, stall, 19'h00556, 19'h00556, 0, 0, rpc, 1, depth, ovf, unf));
    vecs.push_back(mk(1, 1, 0, 0, 1, stall, 19'h00557, 19'h00557, 0, 0, rpc, 0, depth, ovf, unf));
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic drive_idle();
    valid_i = 0; is_b_type_i = 0; is_call_i = 0; is_ret_i = 0;
    branch_taken_i = 0; stall_i = 0; pc_i = '0; target_i = '0;
  endtask

  // Called at a falling edge: drive, check ready, then check registered outputs after the edge.
  task automatic applyStimulus(input vec_t v, input int idx);
    valid_i = v.valid; is_b_type_i = v.b; is_call_i = v.call; is_ret_i = v.ret;
    branch_taken_i = v.taken; stall_i = v.stall; pc_i = v.pc; target_i = v.target;
    #1;
    checkOutput($sformatf("vec%0d.ready", idx), 32'(ready_o), 32'(v.exp_ready));
    @(posedge clk);
    #1;
    checkOutput($sformatf("vec%0d.redirect", idx), 32'(redirect_o), 32'(v.exp_redirect));
    checkOutput($sformatf("vec%0d.redirect_pc", idx), 32'(redirect_pc_o), 32'(v.exp_rpc));
    checkOutput($sformatf("vec%0d.flush", idx), 32'(flush_o), 32'(v.exp_flush));
    checkOutput($sformatf("vec%0d.depth", idx), 32'(depth_o), 32'(v.exp_depth));
    checkOutput($sformatf("vec%0d.ovf", idx), 32'(ovf_o), 32'(v.exp_ovf));
    checkOutput($sformatf("vec%0d.unf", idx), 32'(unf_o), 32'(v.exp_unf));
    @(negedge clk);
  endtask

  task automatic run_queue();
    foreach (vecs[i]) begin
      applyStimulus(vecs[i], vec_idx);
      vec_idx++;
    end
    vecs.delete();
    drive_idle();
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    vec_idx = 0;
    reset_n = 1'b0;
    drive_idle();
    #1;
    checkOutput("reset.redirect", 32'(redirect_o), 32'd0);
    checkOutput("reset.redirect_pc", 32'(redirect_pc_o), 32'd0);
    checkOutput("reset.flush", 32'(flush_o), 32'd0);
    checkOutput("reset.depth", 32'(depth_o), 32'd0);
    checkOutput("reset.ovf", 32'(ovf_o), 32'd0);
    checkOutput("reset.unf", 32'(unf_o), 32'd0);
    checkOutput("reset.ready", 32'(ready_o), 32'd1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Taken BEQ, then not-taken stream and a flagless valid.
    vecs.push_back(mk(1, 1, 0, 0, 1, 0, 19'h00100, 19'h00200, 1, 1, 19'h00200, 1, 0, 0, 0));
    push_flush(19'h00200, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      vecs.push_back(mk(1, 1, 0, 0, 0, 0, 19'h00104 + 19'(i), 19'h00666, 1, 0, 19'h00200, 0, 0, 0, 0));
    end
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 19'h00110, 19'h00777, 1, 0, 19'h00200, 0, 0, 0, 0));
    // Call then ret.
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, 19'h00010, 19'h00400, 1, 1, 19'h00400, 1, 1, 0, 0));
    push_flush(19'h00400, 1, 0, 0, 0);
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 19'h00050, 19'h00999, 1, 1, 19'h00011, 1, 0, 0, 0));
    push_flush(19'h00011, 0, 0, 0, 0);
    // Return-address wrap at the top of the 19-bit space; flush continues under stall.
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, 19'h7FFFF, 19'h00123, 1, 1, 19'h00123, 1, 1, 0, 0));
    push_flush(19'h00123, 1, 0, 0, 0);
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 19'h00060, 19'h00999, 1, 1, 19'h00000, 1, 0, 0, 0));
    push_flush(19'h00000, 0, 0, 0, 1);
    // Priority: call beats branch, ret beats call and branch.
    vecs.push_back(mk(1, 1, 1, 0, 1, 0, 19'h00020, 19'h00700, 1, 1, 19'h00700, 1, 1, 0, 0));
    push_flush(19'h00700, 1, 0, 0, 0);
    vecs.push_back(mk(1, 1, 1, 1, 1, 0, 19'h00030, 19'h00800, 1, 1, 19'h00021, 1, 0, 0, 0));
    push_flush(19'h00021, 0, 0, 0, 0);
    // Stall blocks acceptance until it drops.
    vecs.push_back(mk(1, 1, 0, 0, 1, 1, 19'h00040, 19'h00900, 0, 0, 19'h00021, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 1, 1, 19'h00040, 19'h00900, 0, 0, 19'h00021, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 1, 0, 19'h00040, 19'h00900, 1, 1, 19'h00900, 1, 0, 0, 0));
    push_flush(19'h00900, 0, 0, 0, 1);
    run_queue();

    // Nine calls into an eight-deep stack, then nine rets.
    for (int i = 0; i < 9; i++) begin
      vecs.push_back(mk(1, 0, 1, 0, 0, 0, 19'h01000 + 19'(i), 19'h02000 + 19'(i), 1, 1,
                        19'h02000 + 19'(i), 1, (i < 8) ? 4'(i + 1) : 4'd8, (i == 8), 0));
      push_flush(19'h02000 + 19'(i), (i < 8) ? 4'(i + 1) : 4'd8, (i == 8), 0, 0);
    end
    for (int i = 0; i < 9; i++) begin
      logic [18:0] rpc;
      rpc = (i < 8) ? (19'h01008 - 19'(i)) : 19'h03009;
      vecs.push_back(mk(1, 0, 0, 1, 0, 0, 19'h03000 + 19'(i), 19'h04000, 1, 1, rpc, 1,
                        (i < 8) ? 4'(7 - i) : 4'd0, 1, (i == 8)));
      push_flush(rpc, (i < 8) ? 4'(7 - i) : 4'd0, 1, (i == 8), 0);
    end
    run_queue();

    // Reset in the middle of a flush.
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, 19'h000A0, 19'h00B00, 1, 1, 19'h00B00, 1, 1, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 19'h00000, 19'h00000, 0, 0, 19'h00B00, 1, 1, 1, 1));
    run_queue();
    reset_n = 1'b0;
    #1;
    checkOutput("midreset.flush", 32'(flush_o), 32'd0);
    checkOutput("midreset.redirect", 32'(redirect_o), 32'd0);
    checkOutput("midreset.redirect_pc", 32'(redirect_pc_o), 32'd0);
    checkOutput("midreset.depth", 32'(depth_o), 32'd0);
    checkOutput("midreset.ovf", 32'(ovf_o), 32'd0);
    checkOutput("midreset.unf", 32'(unf_o), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    checkOutput("postreset.ready", 32'(ready_o), 32'd1);
    @(negedge clk);
    vecs.push_back(mk(1, 1, 0, 0, 1, 0, 19'h000C0, 19'h00D00, 1, 1, 19'h00D00, 1, 0, 0, 0));
    push_flush(19'h00D00, 0, 0, 0, 0);
    run_queue();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_sequencer.md
# branch_sequencer

Control-flow sequencer that sits behind the branch comparator in the 19-bit CPU execute stage. It accepts resolved branch, call and return events, issues a one-cycle PC redirect, and holds a pipeline flush for a fixed number of cycles. It owns a hardware return-address stack that call pushes and ret pops, with sticky overflow and underflow flags.

## Interface
- STACK_DEPTH, 8: return-address stack entries; valid range 2..32.
- FLUSH_CYCLES, 2: cycles spent in FLUSH after the redirect cycle; minimum 1.
- clk  input  1  single clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- valid_i  input  1  execute-stage control-flow instruction present.
- is_b_type_i  input  1  conditional branch.
- is_call_i  input  1  call instruction.
- is_ret_i  input  1  return instruction.
- branch_taken_i  input  1  comparator outcome; used only for conditional branches.
- stall_i  input  1  pipeline stall; blocks acceptance.
- pc_i  input  19  PC of the current instruction.
- target_i  input  19  computed branch or call target.
- ready_o  output  1  combinational: high when state is IDLE and stall_i is 0.
- redirect_o  output  1  registered one-cycle PC redirect strobe.
- redirect_pc_o  output  19  registered redirect address; valid only when redirect_o is 1.
- flush_o  output  1  registered; high in the REDIRECT and FLUSH states.
- depth_o  output  $clog2(STACK_DEPTH+1)  current stack occupancy.
- ovf_o  output  1  sticky: a call was issued while the stack was full.
- unf_o  output  1  sticky: a ret was issued while the stack was empty.

## Operation
- Accept condition: valid_i and ready_o both high on a clock edge.
- Event priority when more than one type flag is set: is_ret_i, then is_call_i, then is_b_type_i.
- Conditional branch, taken: redirect to target_i.
- Conditional branch, not taken: no action; state stays IDLE and ready_o stays high. Same for valid_i with no type flag set.
- Call: push pc_i+1 (19-bit modulo, 0x7FFFF+1 = 0x00000) and redirect to target_i.
- Call with the stack full (depth = STACK_DEPTH): push is dropped, ovf_o sets, redirect still goes to target_i.
- Ret with the stack non-empty: pop the top entry and redirect to it.
- Ret with the stack empty: redirect to pc_i+1, unf_o sets, depth_o stays 0.
- Stack is LIFO with a pointer register. Depth changes by exactly one on a push or pop. Contents are not cleared on pop.
- States:
  - IDLE: any redirecting accept goes to REDIRECT.
  - REDIRECT: lasts one cycle, then goes to FLUSH and loads the counter with FLUSH_CYCLES-1.
  - FLUSH: counts down and goes to IDLE after the count reaches 0.
- stall_i only blocks acceptance. REDIRECT and FLUSH progress regardless of stall_i.
- ovf_o and unf_o clear only on reset.
- Reset (asynchronous, at any time, including mid-flush): state IDLE, stack pointer 0.
  - Zero after reset: redirect_o, redirect_pc_o, flush_o, depth_o, ovf_o, unf_o.
  - Any in-progress redirect or flush is aborted.

## Timing
- Accept at edge N.
- Push or pop is visible on depth_o after edge N.
- Cycle N+1: redirect_o=1, flush_o=1, redirect_pc_o valid.
- Cycles N+2 .. N+1+FLUSH_CYCLES: flush_o=1, redirect_o=0.
- ready_o is low from N+1 through N+1+FLUSH_CYCLES.
- Earliest next accept is the edge ending cycle N+2+FLUSH_CYCLES.
- Total flush duration is 1+FLUSH_CYCLES cycles; default 3.
- Not-taken or no-op accepts have zero latency and no bubble.
- redirect_pc_o holds its last value outside the redirect cycle.

## Test plan
- Reset, then a taken BEQ: pc_i=0x00100, target_i=0x00200, default parameters.
  - Next cycle: redirect_o=1 and redirect_pc_o=0x00200.
  - flush_o high for 3 cycles, ready_o low for 3 cycles.
- Not-taken branch stream: valid_i on 4 consecutive cycles with branch_taken_i=0.
  - redirect_o and flush_o stay 0; ready_o stays 1.
- Call then ret:
  - Call at pc 0x00010 to 0x00400: depth_o goes to 1.
  - Ret after the flush: redirect_pc_o=0x00011 and depth_o goes to 0.
- Call at pc 0x7FFFF, then ret: the popped redirect is 0x00000, checking wrap.
- Boundary: 9 calls with STACK_DEPTH=8, then 9 rets.
  - The 9th call sets ovf_o and depth_o stays 8.
  - The 9th ret sets unf_o and redirects to its own pc_i+1.
- Reset asserted during FLUSH: flush_o and all state go 0 immediately; ready_o returns to 1 after release with stall_i=0.
- stall_i high with valid_i and a taken branch: no accept. The event is accepted on the first cycle stall_i is 0.
